axi_ram_slave: RTL and testbench



---
 rtl/axi_ram_slave_pkg.sv | 32 +++
 rtl/axi_lfsr16.sv | 16 +
 rtl/axi_ram_slave.sv | 212 +++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared response codes, channel FSM state encodings and the byte-merge helper
// for the axi_ram_slave memory target.
package axi_ram_slave_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  // Lanes with strb set take new_w, the rest keep old_w; no shifting by address.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise channel stalls
// when the slave is built with AXI_SLV_STALL_EN.
module axi_lfsr16
  import axi_ram_slave_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

endmodule

// File: rtl/axi_ram_slave.sv
// Single-beat AXI3 RAM slave with independent read/write channel FSMs.
// Optional build macro AXI_SLV_STALL_EN adds LFSR-driven ready/response stalls.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Handshakes: a transfer happens on the clock edge where valid && ready are
  // both high; the source holds payload and valid stable until then, and the
  // slave samples master payloads only on that edge.

  logic [31:0] mem [2**ADDR_W];

  rd_state_e   rd_state;
  wr_state_e   wr_state;
  logic        arready_q, awready_q, wready_q;
  logic [3:0]  arid_q, awid_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [7:0]  arlen_q, awlen_q, cnt;
  logic [2:0]  arsize_q, awsize_q;
  logic [3:0]  wstrb_q;
  logic        wlast_q, aw_held, w_held;
  logic [2:0]  ready_gate;
  logic        resp_go;

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;
  axi_lfsr16 u_lfsr (.clk(clk), .resetn(resetn), .lfsr(lfsr));
  assign ready_gate  = lfsr[2:0];
  assign resp_go     = lfsr[3];
  assign unused_lfsr = ^lfsr[15:4];
`else
  assign ready_gate = 3'b111;
  assign resp_go    = 1'b1;
`endif

  assign arready = arready_q & ready_gate[0];
  assign awready = awready_q & ready_gate[1];
  assign wready  = wready_q  & ready_gate[2];

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;

  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic              rd_err, wr_err, wr_commit, wr_en, unused_bits;
  logic [31:0]       rd_word;
  assign rd_idx = araddr_q[ADDR_W+1:2];
  assign wr_idx = awaddr_q[ADDR_W+1:2];
  assign rd_err = (arlen_q != 8'd0) || (arsize_q > 3'd2) || (araddr_q[31:ADDR_W+2] != '0);
  assign wr_err = (awlen_q != 8'd0) || (awsize_q > 3'd2) || (awaddr_q[31:ADDR_W+2] != '0)
                  || !wlast_q;
  assign wr_commit = resetn && (wr_state == W_IDLE) && aw_held && w_held && resp_go;
  assign wr_en     = wr_commit && !wr_err;
  // Write-first bypass so a read sampled on the commit edge sees the merged word.
  assign rd_word = (wr_en && (wr_idx == rd_idx)) ? merge_word(mem[rd_idx], wdata_q, wstrb_q)
                                                 : mem[rd_idx];
  assign unused_bits = ^{wid, araddr_q[1:0], awaddr_q[1:0]};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= merge_word(mem[wr_idx], wdata_q, wstrb_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      cnt       <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arid_q    <= arid;
            araddr_q  <= araddr;
            arlen_q   <= arlen;
            arsize_q  <= arsize;
            cnt       <= 8'(RD_LAT - 1);
            arready_q <= 1'b0;
            rd_state  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (resp_go) begin
            rid      <= arid_q;
            rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata    <= rd_err ? 32'h0 : rd_word;
            rvalid   <= 1'b1;
            rlast    <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= RESP_OKAY;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_commit) begin
            bvalid    <= 1'b1;
            bid       <= awid_q;
            bresp     <= wr_err ? RESP_SLVERR : RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_state  <= W_RESP;
          end else begin
            awready_q <= !(aw_held || aw_hs);
            wready_q  <= !(w_held || w_hs);
            if (aw_hs) begin
              awid_q   <= awid;
              awaddr_q <= awaddr;
              awlen_q  <= awlen;
              awsize_q <= awsize;
              aw_held  <= 1'b1;
            end
            if (w_hs) begin
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              wlast_q <= wlast;
              w_held  <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid    <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave (default build): scoreboarded reads/writes,
// strobes, errors, R back-pressure, write-first collision and mid-flight reset.
module tb_axi_ram_slave;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [37:0] exp_q[$];
  logic [5:0]  bexp_q[$];
  logic [31:0] model_mem [int];

  axi_ram_slave #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] w;
    int k;
    k = int'(addr[13:2]);
    w = model_mem.exists(k) ? model_mem[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    model_mem[k] = w;
  endfunction

  function automatic logic [37:0] exp_read(input logic [3:0] id, input logic [31:0] addr,
                                           input logic [7:0] len, input logic [2:0] size);
    logic err;
    err = (len != 8'd0) || (size > 3'd2) || (addr[31:14] != 18'd0);
    if (err) return {id, 2'b10, 32'h0};
    return {id, 2'b00, model_mem[int'(addr[13:2])]};
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [7:0] len, input logic [2:0] size,
                           input logic last, input int w_lead);
    logic aw_fire, w_fire, aw_done, w_done, err;
    logic [5:0] exp;
    int n;
    err = (len != 8'd0) || (size > 3'd2) || (addr[31:14] != 18'd0) || !last;
    bexp_q.push_back({id, err ? 2'b10 : 2'b00});
    if (!err) model_write(addr, data, strb);
    wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = (w_lead == 0);
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      n++;
      if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1'b1;  wvalid = 1'b0;  end
      if (!aw_done) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    check("b_latency", n, 1);
    exp = bexp_q.pop_front();
    check("bid", bid, exp[5:2]);
    check("bresp", bresp, exp[1:0]);
    check("w_blocked", {awready, wready}, 0);
    tick();
    check("b_done", bvalid, 0);
    check("aw_w_return", {awready, wready}, 3);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int hold);
    logic [37:0] exp;
    logic fire;
    int n;
    exp_q.push_back(exp_read(id, addr, len, size));
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    fire = 1'b0; n = 0;
    while (!fire && n < 50) begin fire = arready; tick(); n++; end
    arvalid = 1'b0;
    check("ar_accept", fire, 1);
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    check("r_latency", n, RD_LAT);
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      tick();
      check("r_hold_valid", rvalid, 1);
      check("r_hold_data", rdata, exp[31:0]);
      check("r_hold_id", rid, exp[37:34]);
    end
    check("ar_blocked", arready, 0);
    check("rid", rid, exp[37:34]);
    check("rresp", rresp, exp[33:32]);
    check("rdata", rdata, exp[31:0]);
    check("rlast", rlast, 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_done", rvalid, 0);
    check("ar_return", arready, 1);
  endtask

  initial begin : main
    logic [37:0] rexp;
    logic [5:0]  bexp;
    logic [31:0] a, d;
    logic [3:0]  s;
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;

    repeat (3) tick();
    check("rst_readies", {arready, awready, wready}, 0);
    check("rst_valids", {rvalid, bvalid, rlast}, 0);
    check("rst_ids", {rid, bid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resps", {rresp, bresp}, 0);
    resetn = 1'b1;
    tick();
    check("post_rst_readies", {arready, awready, wready}, 7);

    // Basic write then read back
    axi_write(4'h3, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, 3'd2, 1'b1, 0);
    axi_read(4'h1, 32'h10, 8'd0, 3'd2, 0);

    // W ahead of AW, single-lane strobe
    axi_write(4'h5, 32'h10, 32'h00AA0000, 4'b0100, 8'd0, 3'd2, 1'b1, 1);
    axi_read(4'h2, 32'h10, 8'd0, 3'd2, 0);
    check("strobe_merge_model", model_mem[4], 32'hDEAABEEF);

    // R back-pressure
    axi_read(4'h7, 32'h10, 8'd0, 3'd2, 5);

    // Error responses
    axi_read(4'h2, 32'h10, 8'd3, 3'd2, 0);
    axi_read(4'h4, 32'h0001_0000, 8'd0, 3'd2, 0);
    axi_read(4'h6, 32'h10, 8'd0, 3'd3, 0);
    axi_write(4'h8, 32'h10, 32'h12345678, 4'hF, 8'd0, 3'd3, 1'b1, 0);
    axi_write(4'h9, 32'h10, 32'h12345678, 4'hF, 8'd0, 3'd2, 1'b0, 0);
    axi_write(4'hA, 32'h0001_0010, 32'h12345678, 4'hF, 8'd0, 3'd2, 1'b1, 0);
    axi_read(4'hB, 32'h10, 8'd0, 3'd2, 0);

    // Write commit and read sample on the same edge, same word
    axi_write(4'h1, 32'h20, 32'h11111111, 4'hF, 8'd0, 3'd2, 1'b1, 0);
    bexp_q.push_back({4'hC, 2'b00});
    model_write(32'h20, 32'h0000F00D, 4'b0011);
    exp_q.push_back(exp_read(4'hD, 32'h20, 8'd0, 3'd2));
    arid = 4'hD; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arvalid = 1'b1;
    awid = 4'hC; awaddr = 32'h20; awlen = 8'd0; awsize = 3'd2; awvalid = 1'b1;
    wdata = 32'h0000F00D; wstrb = 4'b0011; wlast = 1'b1; wvalid = 1'b1;
    check("coll_readies", {arready, awready, wready}, 7);
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_not_early", {rvalid, bvalid}, 0);
    tick();
    check("coll_both_valid", {rvalid, bvalid}, 3);
    rexp = exp_q.pop_front();
    bexp = bexp_q.pop_front();
    check("coll_rdata", rdata, rexp[31:0]);
    check("coll_rdata_const", rdata, 32'h1111F00D);
    check("coll_rid", rid, rexp[37:34]);
    check("coll_bid", {bid, bresp}, bexp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("coll_done", {rvalid, bvalid}, 0);

    // Randomised full + partial writes with read-back
    for (int i = 0; i < 6; i++) begin
      a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
      d = $urandom;
      axi_write(4'(i), a, d, 4'hF, 8'd0, 3'd2, 1'b1, 0);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      axi_write(4'(i + 1), a, d, s, 8'd0, 3'd2, 1'b1, int'($urandom_range(0, 1)));
      axi_read(4'(i + 2), a + 32'($urandom_range(0, 3)), 8'd0, 3'($urandom_range(0, 2)), 0);
    end

    // Reset with an R beat pending and an AW held
    arid = 4'h9; araddr = 32'h10; arvalid = 1'b1;
    awid = 4'h2; awaddr = 32'h30; awlen = 8'd0; awsize = 3'd2; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    tick();
    check("rst_pre_rvalid", rvalid, 1);
    resetn = 1'b0;
    tick();
    check("rst_mid_valids", {rvalid, rlast, bvalid}, 0);
    check("rst_mid_readies", {arready, awready, wready}, 0);
    resetn = 1'b1;
    tick();
    check("rst_mid_release", {arready, awready, wready}, 7);
    rready = 1'b1;
    wdata = 32'h55555555; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_stale", {rvalid, bvalid}, 0);
    end
    rready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
